// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment frame scanner: segment codes,
// blank code and the ghost-guard length.
package ssd_pkg;

  // Active-low cathode patterns in {a,b,c,d,e,f,g} order, indexed by hex value.
  localparam logic [6:0] SEG_CODE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam int unsigned GHOST_LEN = 4;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_CODE[hex];
  end

endmodule

// File: rtl/ssd_frame_scanner.sv
// Multiplexed seven-segment scanner with double-buffered, tear-free frames.
// Define SSD_DP_EN to add the per-digit decimal-point input DpIn.
module ssd_frame_scanner
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE_W = 18
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Load,
  output logic                    Ready,
  input  logic [4*NUM_DIGITS-1:0] Digits,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic                    LzbEn,
`ifdef SSD_DP_EN
  input  logic [NUM_DIGITS-1:0]   DpIn,
`endif
  output logic [NUM_DIGITS-1:0]   An,
  output logic [6:0]              Cath,
  output logic                    Dp,
  output logic                    FrameDone
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pend_full_q, pend_full_d;
  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                    pend_lzb_q, pend_lzb_d;
  logic [4*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
  logic [NUM_DIGITS-1:0]   disp_en_q, disp_en_d;
  logic                    disp_lzb_q, disp_lzb_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              cath_q, cath_d;
`ifdef SSD_DP_EN
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    dp_q, dp_d;
`endif

  logic                    slot_end;
  logic                    boundary;
  logic                    accept;
  logic                    guard;
  logic                    lit;
  logic [3:0]              cur_hex;
  logic [6:0]              cur_seg;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS:1]     zero_from;
  logic [NUM_DIGITS-1:0]   blank;

  assign slot_end = &presc_q;
  assign boundary = slot_end && (idx_q == LAST_IDX);
  assign accept   = Load && !pend_full_q;
  assign guard    = (32'(presc_q) < GHOST_LEN);

  // zero_from[k]: every nibble from k up to the leftmost digit is zero.
  assign zero_from[NUM_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = disp_digits_q[4*gi +: 4];
    if (gi == 0) begin : g_first
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign zero_from[gi] = (nib[gi] == 4'd0) && zero_from[gi+1];
      assign blank[gi]     = disp_lzb_q && zero_from[gi];
    end
  end

  assign cur_hex = nib[idx_q];
  assign lit     = !guard && disp_en_q[idx_q] && !blank[idx_q];

  ssd_hex_decoder u_dec (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  always_comb begin
    presc_d       = presc_q + PRESCALE_W'(1);
    idx_d         = idx_q;
    pend_full_d   = pend_full_q;
    pend_digits_d = pend_digits_q;
    pend_en_d     = pend_en_q;
    pend_lzb_d    = pend_lzb_q;
    disp_digits_d = disp_digits_q;
    disp_en_d     = disp_en_q;
    disp_lzb_d    = disp_lzb_q;
`ifdef SSD_DP_EN
    pend_dp_d     = pend_dp_q;
    disp_dp_d     = disp_dp_q;
`endif

    if (slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end

    // Display only ever changes here, so a frame is never mixed.
    if (boundary) begin
      if (pend_full_q) begin
        disp_digits_d = pend_digits_q;
        disp_en_d     = pend_en_q;
        disp_lzb_d    = pend_lzb_q;
`ifdef SSD_DP_EN
        disp_dp_d     = pend_dp_q;
`endif
        pend_full_d   = 1'b0;
      end else if (Load) begin
        disp_digits_d = Digits;
        disp_en_d     = DigitEn;
        disp_lzb_d    = LzbEn;
`ifdef SSD_DP_EN
        disp_dp_d     = DpIn;
`endif
      end
    end else if (accept) begin
      pend_digits_d = Digits;
      pend_en_d     = DigitEn;
      pend_lzb_d    = LzbEn;
`ifdef SSD_DP_EN
      pend_dp_d     = DpIn;
`endif
      pend_full_d   = 1'b1;
    end

    an_d   = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    cath_d = lit ? cur_seg : SEG_BLANK;
`ifdef SSD_DP_EN
    dp_d   = lit ? ~disp_dp_q[idx_q] : 1'b1;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pend_full_q   <= 1'b0;
      pend_digits_q <= '0;
      pend_en_q     <= '0;
      pend_lzb_q    <= 1'b0;
      disp_digits_q <= '0;
      disp_en_q     <= '1;
      disp_lzb_q    <= 1'b1;
      an_q          <= '1;
      cath_q        <= SEG_BLANK;
`ifdef SSD_DP_EN
      pend_dp_q     <= '0;
      disp_dp_q     <= '0;
      dp_q          <= 1'b1;
`endif
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pend_full_q   <= pend_full_d;
      pend_digits_q <= pend_digits_d;
      pend_en_q     <= pend_en_d;
      pend_lzb_q    <= pend_lzb_d;
      disp_digits_q <= disp_digits_d;
      disp_en_q     <= disp_en_d;
      disp_lzb_q    <= disp_lzb_d;
      an_q          <= an_d;
      cath_q        <= cath_d;
`ifdef SSD_DP_EN
      pend_dp_q     <= pend_dp_d;
      disp_dp_q     <= disp_dp_d;
      dp_q          <= dp_d;
`endif
    end
  end

  assign Ready     = !pend_full_q;
  assign FrameDone = boundary;
  assign An        = an_q;
  assign Cath      = cath_q;
`ifdef SSD_DP_EN
  assign Dp        = dp_q;
`else
  assign Dp        = 1'b1;
`endif

endmodule

// File: tb/tb_ssd_frame_scanner.sv
// Self-checking bench for ssd_frame_scanner (4 digits, 8-clock slots) against
// a frame-level reference model; also exercises SSD_DP_EN when defined.
module tb_ssd_frame_scanner;

  localparam int ND    = 4;
  localparam int PW    = 3;
  localparam int SLOT  = 8;
  localparam int FRAME = ND * SLOT;

  logic        Clk     = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Load    = 1'b0;
  logic        LzbEn   = 1'b0;
  logic [15:0] Digits  = '0;
  logic [3:0]  DigitEn = '0;
`ifdef SSD_DP_EN
  logic [3:0]  DpIn    = '0;
`endif
  logic        Ready;
  logic        Dp;
  logic        FrameDone;
  logic [3:0]  An;
  logic [6:0]  Cath;

  ssd_frame_scanner #(.NUM_DIGITS(ND), .PRESCALE_W(PW)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Load      (Load),
    .Ready     (Ready),
    .Digits    (Digits),
    .DigitEn   (DigitEn),
    .LzbEn     (LzbEn),
`ifdef SSD_DP_EN
    .DpIn      (DpIn),
`endif
    .An        (An),
    .Cath      (Cath),
    .Dp        (Dp),
    .FrameDone (FrameDone)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] dg;
    logic [3:0]  en;
    logic        lz;
    logic [3:0]  dp;
  } frame_t;

  // Content shown in each frame since the last reset release.
  frame_t frame_disp [128];
  bit     loaded     [128];
  int     e;               // clock edges since reset release
  int     last_acc_frame;  // frame in which the last load was accepted
  int     checks = 0;
  int     errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at edge %0d", tag, obs, exp, e);
    end
  endtask

  task automatic chk_reset();
    chk("rst_an", {12'b0, An}, 16'h000F);
    chk("rst_cath", {9'b0, Cath}, 16'h007F);
    chk("rst_dp", {15'b0, Dp}, 16'h0001);
    chk("rst_ready", {15'b0, Ready}, 16'h0001);
    chk("rst_framedone", {15'b0, FrameDone}, 16'h0000);
  endtask

  // Outputs seen after edge e describe scan position e-1.
  task automatic check_outputs();
    logic [3:0]  an_e;
    logic [6:0]  cath_e;
    logic        dp_e;
    logic [15:0] sh;
    frame_t      d;
    int          p, slot, off;
    bit          vis;
    an_e   = 4'hF;
    cath_e = 7'h7F;
    dp_e   = 1'b1;
    if (e > 0) begin
      p    = e - 1;
      slot = (p / SLOT) % ND;
      off  = p % SLOT;
      d    = frame_disp[p / FRAME];
      sh   = d.dg >> (4 * slot);
      vis  = (off >= 4) && d.en[slot] && !(slot > 0 && d.lz && sh == 16'd0);
      if (vis) begin
        an_e   = ~(4'b0001 << slot);
        cath_e = seg_tab[sh[3:0]];
`ifdef SSD_DP_EN
        dp_e   = ~d.dp[slot];
`endif
      end
    end
    chk("an", {12'b0, An}, {12'b0, an_e});
    chk("cath", {9'b0, Cath}, {9'b0, cath_e});
    chk("dp", {15'b0, Dp}, {15'b0, dp_e});
    chk("ready", {15'b0, Ready}, {15'b0, (last_acc_frame != e / FRAME)});
    chk("framedone", {15'b0, FrameDone}, {15'b0, (e % FRAME == FRAME - 1)});
  endtask

  // One clock: check outputs, drive inputs, update model, advance to next negedge.
  task automatic step(input bit ld, input logic [15:0] dg, input logic [3:0] en,
                      input bit lz, input logic [3:0] dp);
    bit rdy;
    int f;
    check_outputs();
    Load    = ld;
    Digits  = dg;
    DigitEn = en;
    LzbEn   = lz;
`ifdef SSD_DP_EN
    DpIn    = dp;
`endif
    f   = e / FRAME;
    rdy = (last_acc_frame != f);
    if (ld && rdy) begin
      frame_disp[f+1] = '{dg: dg, en: en, lz: lz, dp: dp};
      loaded[f+1]     = 1'b1;
      last_acc_frame  = f;
      $display("load edge=%0d digits=%h en=%b lzb=%0d dp=%b accepted for frame %0d",
               e, dg, en, lz, dp, f + 1);
    end else if (ld) begin
      $display("load edge=%0d digits=%h en=%b lzb=%0d dp=%b dropped (buffer busy)",
               e, dg, en, lz, dp);
    end
    @(posedge Clk);
    e++;
    if (e % FRAME == 0 && !loaded[e / FRAME]) begin
      frame_disp[e / FRAME] = frame_disp[e / FRAME - 1];
    end
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    Load    = 1'b0;
    repeat (2) @(negedge Clk);
    chk_reset();
    repeat (2) @(negedge Clk);
    chk_reset();
    Reset_n = 1'b1;
    for (int i = 0; i < 128; i++) loaded[i] = 1'b0;
    frame_disp[0]  = '{dg: 16'h0000, en: 4'hF, lz: 1'b1, dp: 4'h0};
    last_acc_frame = -1;
    e              = 0;
    $display("reset released");
  endtask

  task automatic idle_until(input int target);
    while (e < target) step(1'b0, 16'h0, 4'h0, 1'b0, 4'h0);
  endtask

  initial begin
    do_reset();
    // Reset content: only digit 0 shows '0'.
    idle_until(40);

    // Mid-frame load of 12AF in slot 1, then a load while busy.
    do_reset();
    idle_until(9);
    step(1'b1, 16'h12AF, 4'hF, 1'b0, 4'b0100);
    step(1'b1, 16'h3333, 4'hF, 1'b0, 4'b0000);
    // Load on the boundary cycle goes straight to the display.
    idle_until(63);
    step(1'b1, 16'h0050, 4'hF, 1'b1, 4'b0100);
    idle_until(70);
    step(1'b1, 16'h0050, 4'b1110, 1'b1, 4'b0001);
    idle_until(140);

    // Randomised loads with leading-zero-heavy data.
    while (e < 1700) begin
      logic [15:0] dg;
      logic [3:0]  en;
      int          zeros;
      dg    = 16'($urandom);
      zeros = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) dg = dg & (16'hFFFF >> (4 * zeros));
      en    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      step(($urandom_range(0, 9) == 0), dg, en, 1'($urandom), 4'($urandom));
    end

    // Reset in slot 2 with the pending buffer full.
    while (e % FRAME != 16) step(1'b0, 16'h0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 16'hBEEF, 4'hF, 1'b0, 4'h1);
    do_reset();
    idle_until(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
